// File: rtl/muxn_arb.sv
// N:1 arbitrated mux with valid/ready per channel and one registered output stage.
// Optional packet lock (in_last/out_last) is enabled by defining MUXN_ARB_LOCK_EN.
module muxn_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N       = 4,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned SW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
`ifdef MUXN_ARB_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
`ifdef MUXN_ARB_LOCK_EN
  output logic                 out_last,
`endif
  input  logic                 out_ready
);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    win;
  logic             found;
  logic             load;
  logic             accept;
  logic [N-1:0]     grant;
  logic [N-1:0]     rot;
  logic [2*N-1:0]   dbl;
  logic [WIDTH-1:0] win_data;

`ifdef MUXN_ARB_LOCK_EN
  logic             locked;
  logic [SW-1:0]    lock_ch;
  logic             win_last;
`endif

  // Rotate valids so the pointer sits at bit 0, then take the first set bit.
  always_comb begin
    dbl   = {in_valid, in_valid};
    rot   = N'(dbl >> ptr);
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = SW'((32'(ptr) + 32'(k)) % N);
      end
    end
`ifdef MUXN_ARB_LOCK_EN
    if (locked) begin
      found = |(in_valid & (N'(1) << lock_ch));
      win   = lock_ch;
    end
`endif
  end

  assign grant    = found ? (N'(1) << win) : '0;
  assign load     = !out_valid || out_ready;
  assign accept   = found && load;
  assign in_ready = {N{accept && reset_n}} & grant;
  assign win_data = WIDTH'(in_data >> (32'(win) * WIDTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_sel   <= win;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Fixed-priority builds tie the pointer to zero and keep no state.
  if (RR_MODE != 0) begin : g_rr
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= (32'(win) == N - 1) ? '0 : SW'(win + 1'b1);
      end
    end
  end else begin : g_fp
    assign ptr = '0;
  end

`ifdef MUXN_ARB_LOCK_EN
  assign win_last = |(in_last & grant);

  // A beat without last pins arbitration to its channel until the closing beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      locked   <= !win_last;
      lock_ch  <= win;
      out_last <= win_last;
    end
  end
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb: one round-robin and one fixed-priority instance
// share stimulus; a behavioural arbiter model predicts grants and output beats.
module tb_muxn_arb;
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic [N-1:0]   in_last;

  logic [N-1:0]   rdy_rr, rdy_fp;
  logic           ov_rr, ov_fp;
  logic [W-1:0]   od_rr, od_fp;
  logic [SW-1:0]  os_rr, os_fp;
  logic           ol_rr, ol_fp;

  beat_t q0[$];
  beat_t q1[$];
  int    mptr[2];
  bit    mvalid[2];
  bit    mlock[2];
  int    mlch[2];
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

`ifndef MUXN_ARB_LOCK_EN
  assign ol_rr = 1'b0;
  assign ol_fp = 1'b0;
`endif

  muxn_arb #(.WIDTH(W), .N(N), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
`ifdef MUXN_ARB_LOCK_EN
    .in_last(in_last), .out_last(ol_rr),
`endif
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready)
  );

  muxn_arb #(.WIDTH(W), .N(N), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
`ifdef MUXN_ARB_LOCK_EN
    .in_last(in_last), .out_last(ol_fp),
`endif
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chan_valid(input int c);
    return ((in_valid >> c) & N'(1)) != '0;
  endfunction

  // Winner by the arbitration rules: lock first, else search from the pointer (or 0).
  function automatic int winner(input int m);
`ifdef MUXN_ARB_LOCK_EN
    if (mlock[m]) return chan_valid(mlch[m]) ? mlch[m] : -1;
`endif
    for (int k = 0; k < int'(N); k++) begin
      int c;
      c = (m == 1) ? (mptr[m] + k) % int'(N) : k;
      if (chan_valid(c)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mptr[m] = 0; mvalid[m] = 1'b0; mlock[m] = 1'b0; mlch[m] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Predict this cycle's handshake and queue the beat that the next edge will register.
  task automatic model_eval();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] rdy, exp_rdy;
      logic         ov;
      bit           load;
      int           w;
      beat_t        b;
      rdy = (m == 1) ? rdy_rr : rdy_fp;
      ov  = (m == 1) ? ov_rr : ov_fp;
      if (!reset_n) begin
        check($sformatf("in_ready_reset_m%0d", m), 64'(rdy), 64'(0));
        continue;
      end
      check($sformatf("out_valid_m%0d", m), 64'(ov), 64'(mvalid[m]));
      load = !mvalid[m] || out_ready;
      w = winner(m);
      exp_rdy = (w >= 0 && load) ? (N'(1) << w) : '0;
      check($sformatf("in_ready_m%0d", m), 64'(rdy), 64'(exp_rdy));
      if (w >= 0 && load) begin
        b.data = W'(in_data >> (w * int'(W)));
        b.sel  = SW'(w);
        b.last = ((in_last >> w) & N'(1)) != '0;
`ifndef MUXN_ARB_LOCK_EN
        b.last = 1'b0;
`endif
        if (m == 1) q1.push_back(b); else q0.push_back(b);
        mvalid[m] = 1'b1;
        if (m == 1) mptr[m] = (w + 1) % int'(N);
        mlock[m] = !b.last;
        mlch[m]  = w;
      end else if (out_ready) begin
        mvalid[m] = 1'b0;
      end
    end
  endtask

  // Monitor: every presented beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic v, l;
      logic [W-1:0] d;
      logic [SW-1:0] s;
      beat_t e;
      v = (m == 1) ? ov_rr : ov_fp;
      d = (m == 1) ? od_rr : od_fp;
      s = (m == 1) ? os_rr : os_fp;
      l = (m == 1) ? ol_rr : ol_fp;
      if (v === 1'b1) begin
        if (((m == 1) ? q1.size() : q0.size()) == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat_m%0d: got data %0h sel %0d with nothing expected", m, d, s);
        end else begin
          e = (m == 1) ? q1[0] : q0[0];
          check($sformatf("sb_data_m%0d", m), 64'(d), 64'(e.data));
          check($sformatf("sb_sel_m%0d", m), 64'(s), 64'(e.sel));
`ifdef MUXN_ARB_LOCK_EN
          check($sformatf("sb_last_m%0d", m), 64'(l), 64'(e.last));
`endif
          if (out_ready) begin
            if (m == 1) void'(q1.pop_front()); else void'(q0.pop_front());
          end
        end
      end
    end
  end

  // Inputs are applied at posedge+1; the model samples at posedge+3.
  task automatic cycle();
    #2 model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1 model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; in_last = '1;
    model_reset();
    @(posedge clk);
    #1 in_valid = '1;
    #1;
    check("reset_ready_rr", 64'(rdy_rr), 64'(0));
    check("reset_ready_fp", 64'(rdy_fp), 64'(0));
    check("reset_ov_rr", 64'(ov_rr), 64'(0));
    check("reset_os_rr", 64'(os_rr), 64'(0));
    in_valid = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(); cycle();

    // Single channel, then drain.
    in_valid = 4'b0100; set_data('0, '0, 32'hAAAA_AAAA, '0); out_ready = 1'b1;
    cycle();
    check("single_ov", 64'(ov_rr), 64'(1));
    check("single_data", 64'(od_rr), 64'h0000_0000_AAAA_AAAA);
    check("single_sel", 64'(os_rr), 64'(2));
    in_valid = '0;
    cycle(); cycle();
    check("drain_ov", 64'(ov_rr), 64'(0));
    check("drain_hold_data", 64'(od_rr), 64'h0000_0000_AAAA_AAAA);
    check("drain_hold_sel", 64'(os_rr), 64'(2));

    // Round-robin wrap against fixed priority.
    do_reset();
    in_valid = '1; set_data(32'h0, 32'h5555_5555, 32'hFFFF_0000, 32'h0000_FFFF);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("rr_seq_%0d", k), 64'(os_rr), 64'(rr_exp[k]));
      check($sformatf("fp_seq_%0d", k), 64'(os_fp), 64'(0));
    end

    // Backpressure with channels 1 and 3 pending.
    in_valid = 4'b1010; set_data(32'h11, 32'h22, 32'h33, 32'h44); out_ready = 1'b0;
    cycle(); cycle(); cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

`ifdef MUXN_ARB_LOCK_EN
    // Packet lock: channel 0 holds the grant through its three-beat packet.
    do_reset();
    in_valid = 4'b0011; in_last = 4'b0000; set_data(32'hC0, 32'hC1, 32'h0, 32'h0);
    cycle();
    check("lock_sel_0", 64'(os_rr), 64'(0));
    cycle();
    check("lock_sel_1", 64'(os_rr), 64'(0));
    check("lock_last_1", 64'(ol_rr), 64'(0));
    in_last = 4'b0001;
    cycle();
    check("lock_sel_2", 64'(os_rr), 64'(0));
    check("lock_last_2", 64'(ol_rr), 64'(1));
    in_valid = 4'b0010;
    cycle();
    check("lock_sel_3", 64'(os_rr), 64'(1));
    check("lock_sel_3_fp", 64'(os_fp), 64'(1));
    check("lock_last_3", 64'(ol_rr), 64'(0));
`endif

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = N'($urandom);
      set_data($urandom, $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_last   = N'($urandom);
      cycle();
    end

    // Asynchronous reset while a beat is held.
    in_valid = '1; out_ready = 1'b0; in_last = '1;
    cycle(); cycle();
    check("pre_reset_ov", 64'(ov_rr), 64'(1));
    reset_n = 1'b0;
    #1;
    check("async_ov_rr", 64'(ov_rr), 64'(0));
    check("async_od_rr", 64'(od_rr), 64'(0));
    check("async_os_rr", 64'(os_rr), 64'(0));
    check("async_ov_fp", 64'(ov_fp), 64'(0));
    check("async_od_fp", 64'(od_fp), 64'(0));
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1; in_valid = '0; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("post_reset_ov", 64'(ov_rr), 64'(0));
    check("q_empty_rr", 64'(q1.size()), 64'(0));
    check("q_empty_fp", 64'(q0.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
